// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared state encoding and default geometry for the associative-memory controller
package am_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUERY = 3'd1,
        S_INFER = 3'd2,
        S_TALLY = 3'd3,
        S_DONE  = 3'd4
    } am_state_e;

    localparam int AM_NUM_SEGMENTS = 10;
    localparam int AM_NUM_CLASSES  = 26;

endpackage

// File: rtl/am_argmax_seq.sv
// rtl/am_argmax_seq.sv - serial best-score/index tracker; first class loads, later classes replace only on strictly greater score
module am_argmax_seq #(
    parameter int SCORE_W = 16,
    parameter int CLS_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic               update,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [CLS_W-1:0]   idx_in,
    output logic [CLS_W-1:0]   best_idx
);

    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [CLS_W-1:0]   best_idx_q, best_idx_d;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        if (load) begin
            best_score_d = score_in;
            best_idx_d   = idx_in;
        end else if (update && (score_in > best_score_q)) begin
            best_score_d = score_in;
            best_idx_d   = idx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_score_q <= '0;
            best_idx_q   <= '0;
        end else if (en) begin
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign best_idx = best_idx_q;

endmodule

// File: rtl/am_ctrl_param.sv
// rtl/am_ctrl_param.sv - AM controller: segment compare, serial argmax, accuracy tally; AM_CYCLE_CNT_EN adds cycle_cnt
module am_ctrl_param
    import am_pkg::*;
#(
    parameter int NUM_SEGMENTS = AM_NUM_SEGMENTS,
    parameter int NUM_CLASSES  = AM_NUM_CLASSES,
    parameter int SCORE_W      = 16,
    parameter int CNT_W        = 16,
    parameter int SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int CLS_W        = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               seg_valid,
    input  logic               dataset_last,
    input  logic [CLS_W-1:0]   label_in,
    input  logic [SCORE_W-1:0] class_score,
    output logic [SEG_W-1:0]   seg_ctr,
    output logic [CLS_W-1:0]   class_idx,
    output logic               comparing,
    output logic               inferring,
    output logic               tallying,
    output logic [CLS_W-1:0]   pred_class,
    output logic               pred_valid,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic [CNT_W-1:0]   total_cnt,
    output logic               done,
    output logic               busy
`ifdef AM_CYCLE_CNT_EN
    ,
    output logic [31:0]        cycle_cnt
`endif
);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    am_state_e        state_q, state_d;
    logic [SEG_W-1:0] seg_ctr_q, seg_ctr_d;
    logic [CLS_W-1:0] class_idx_q, class_idx_d;
    logic [CLS_W-1:0] pred_class_q, pred_class_d;
    logic             pred_valid_q, pred_valid_d;
    logic [CNT_W-1:0] correct_cnt_q, correct_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    logic             argmax_load, argmax_update;
    logic [CLS_W-1:0] best_idx;

    am_argmax_seq #(
        .SCORE_W (SCORE_W),
        .CLS_W   (CLS_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (argmax_load),
        .update   (argmax_update),
        .score_in (class_score),
        .idx_in   (class_idx_q),
        .best_idx (best_idx)
    );

    always_comb begin
        state_d       = state_q;
        seg_ctr_d     = seg_ctr_q;
        class_idx_d   = class_idx_q;
        pred_class_d  = pred_class_q;
        pred_valid_d  = 1'b0;
        correct_cnt_d = correct_cnt_q;
        total_cnt_d   = total_cnt_q;
        argmax_load   = 1'b0;
        argmax_update = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_QUERY;
                    seg_ctr_d     = '0;
                    correct_cnt_d = '0;
                    total_cnt_d   = '0;
                end
            end
            S_QUERY: begin
                if (seg_valid) begin
                    if (seg_ctr_q == SEG_LAST) begin
                        seg_ctr_d   = '0;
                        class_idx_d = '0;
                        state_d     = S_INFER;
                    end else begin
                        seg_ctr_d = seg_ctr_q + 1'b1;
                    end
                end
            end
            S_INFER: begin
                argmax_load   = (class_idx_q == '0);
                argmax_update = (class_idx_q != '0);
                if (class_idx_q == CLS_LAST) begin
                    class_idx_d = '0;
                    state_d     = S_TALLY;
                end else begin
                    class_idx_d = class_idx_q + 1'b1;
                end
            end
            S_TALLY: begin
                pred_class_d = best_idx;
                pred_valid_d = 1'b1;
                total_cnt_d  = sat_inc(total_cnt_q);
                if (best_idx == label_in) begin
                    correct_cnt_d = sat_inc(correct_cnt_q);
                end
                state_d = dataset_last ? S_DONE : S_QUERY;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            seg_ctr_q     <= '0;
            class_idx_q   <= '0;
            pred_class_q  <= '0;
            pred_valid_q  <= 1'b0;
            correct_cnt_q <= '0;
            total_cnt_q   <= '0;
        end else if (en) begin
            state_q       <= state_d;
            seg_ctr_q     <= seg_ctr_d;
            class_idx_q   <= class_idx_d;
            pred_class_q  <= pred_class_d;
            pred_valid_q  <= pred_valid_d;
            correct_cnt_q <= correct_cnt_d;
            total_cnt_q   <= total_cnt_d;
        end
    end

`ifdef AM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    // Busy cycles only; the value is left untouched in IDLE so it stays readable after done.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            cycle_cnt_d = '0;
        end else if ((state_q != S_IDLE) && !(&cycle_cnt_q)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else if (en) begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

    assign seg_ctr     = seg_ctr_q;
    assign class_idx   = class_idx_q;
    assign pred_class  = pred_class_q;
    assign pred_valid  = pred_valid_q;
    assign correct_cnt = correct_cnt_q;
    assign total_cnt   = total_cnt_q;
    assign comparing   = (state_q == S_QUERY);
    assign inferring   = (state_q == S_INFER);
    assign tallying    = (state_q == S_TALLY);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_am_ctrl_param.sv
// tb/tb_am_ctrl_param.sv - randomized self-checking bench for am_ctrl_param (default and CNT_W=2 instances)
module tb_am_ctrl_param;

    localparam int NS  = 10;
    localparam int NC  = 26;
    localparam int SW  = 16;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int SGW = 4;
    localparam int CLW = 5;
    localparam int QLAT = NS + NC + 1;

    logic clk = 1'b0;
    logic rst, en, start, seg_valid, dataset_last;
    logic [CLW-1:0] label_in;
    logic [SW-1:0]  score_tab [NC];
    logic [SW-1:0]  score_a, score_b;

    logic [SGW-1:0] seg_ctr_a, seg_ctr_b;
    logic [CLW-1:0] class_idx_a, class_idx_b, pred_class_a, pred_class_b;
    logic comparing_a, inferring_a, tallying_a, pred_valid_a, done_a, busy_a;
    logic comparing_b, inferring_b, tallying_b, pred_valid_b, done_b, busy_b;
    logic [CW-1:0]  correct_a, total_a;
    logic [CWS-1:0] correct_b, total_b;
`ifdef AM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_a, cycle_cnt_b;
`endif

    int checks = 0;
    int failures = 0;
    int exp_corr_a, exp_tot_a, exp_corr_b, exp_tot_b;

    always #5 clk = ~clk;

    always_comb score_a = score_tab[class_idx_a];
    always_comb score_b = score_tab[class_idx_b];

    am_ctrl_param u_dut_a (
        .clk(clk), .rst(rst), .en(en), .start(start), .seg_valid(seg_valid),
        .dataset_last(dataset_last), .label_in(label_in), .class_score(score_a),
        .seg_ctr(seg_ctr_a), .class_idx(class_idx_a), .comparing(comparing_a),
        .inferring(inferring_a), .tallying(tallying_a), .pred_class(pred_class_a),
        .pred_valid(pred_valid_a), .correct_cnt(correct_a), .total_cnt(total_a),
        .done(done_a), .busy(busy_a)
`ifdef AM_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt_a)
`endif
    );

    am_ctrl_param #(.CNT_W(CWS)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .start(start), .seg_valid(seg_valid),
        .dataset_last(dataset_last), .label_in(label_in), .class_score(score_b),
        .seg_ctr(seg_ctr_b), .class_idx(class_idx_b), .comparing(comparing_b),
        .inferring(inferring_b), .tallying(tallying_b), .pred_class(pred_class_b),
        .pred_valid(pred_valid_b), .correct_cnt(correct_b), .total_cnt(total_b),
        .done(done_b), .busy(busy_b)
`ifdef AM_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt_b)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference argmax: index of the first occurrence of the maximum score.
    function automatic int ref_argmax();
        int bi = 0;
        for (int i = 1; i < NC; i++) begin
            if (score_tab[i] > score_tab[bi]) bi = i;
        end
        return bi;
    endfunction

    function automatic int sat_add(input int v, input int width);
        return (v + 1 > (1 << width) - 1) ? v : v + 1;
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < NC; i++) score_tab[i] = SW'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NC; i++) score_tab[i] = SW'($urandom_range(0, 20));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy_a, 0);
        check_val({tag, "_seg"}, seg_ctr_a, 0);
        check_val({tag, "_cls"}, class_idx_a, 0);
        check_val({tag, "_pred"}, pred_class_a, 0);
        check_val({tag, "_pvalid"}, pred_valid_a, 0);
        check_val({tag, "_corr"}, correct_a, 0);
        check_val({tag, "_tot"}, total_a, 0);
        check_val({tag, "_done"}, done_a, 0);
        check_val({tag, "_tot_b"}, total_b, 0);
`ifdef AM_CYCLE_CNT_EN
        check_val({tag, "_cyc"}, cycle_cnt_a, 0);
`endif
    endtask

    task automatic start_run(input string tag);
        en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_corr_a = 0; exp_tot_a = 0; exp_corr_b = 0; exp_tot_b = 0;
        check_val({tag, "_start_cmp"}, comparing_a, 1);
        check_val({tag, "_start_tot"}, total_a, 0);
        check_val({tag, "_start_corr"}, correct_a, 0);
    endtask

    task automatic run_query(input string tag, input int label, input bit last, input bit toggle);
        int cmp_n = 0, inf_n = 0, tal_n = 0, steps = 0, frz_bad = 0, pred;
        bit ph = 1'b0, en_now, was_tally = 1'b0;
        logic [SGW-1:0] pseg;
        logic [CLW-1:0] pcls;
        logic [2:0] pst;
        pred = ref_argmax();
        label_in = CLW'(label);
        dataset_last = last;
        seg_valid = 1'b1;
        while (!was_tally && steps < 400) begin
            en = toggle ? ph : 1'b1;
            ph = ~ph;
            en_now = en;
            pseg = seg_ctr_a;
            pcls = class_idx_a;
            pst = {comparing_a, inferring_a, tallying_a};
            if (en_now) begin
                cmp_n += int'(comparing_a);
                inf_n += int'(inferring_a);
                tal_n += int'(tallying_a);
                was_tally = tallying_a;
            end
            step();
            steps++;
            if (!en_now && (seg_ctr_a !== pseg || class_idx_a !== pcls ||
                            {comparing_a, inferring_a, tallying_a} !== pst)) frz_bad++;
        end
        en = 1'b1;
        check_val({tag, "_reached_tally"}, was_tally, 1);
        check_val({tag, "_query_cycles"}, cmp_n, NS);
        check_val({tag, "_infer_cycles"}, inf_n, NC);
        check_val({tag, "_tally_cycles"}, tal_n, 1);
        check_val({tag, "_freeze"}, frz_bad, 0);
        if (!toggle) check_val({tag, "_latency"}, steps, QLAT);
        exp_tot_a = sat_add(exp_tot_a, CW);
        exp_tot_b = sat_add(exp_tot_b, CWS);
        if (pred == label) begin
            exp_corr_a = sat_add(exp_corr_a, CW);
            exp_corr_b = sat_add(exp_corr_b, CWS);
        end
        check_val({tag, "_pvalid"}, pred_valid_a, 1);
        check_val({tag, "_pred"}, pred_class_a, pred);
        check_val({tag, "_corr"}, correct_a, exp_corr_a);
        check_val({tag, "_tot"}, total_a, exp_tot_a);
        check_val({tag, "_corr_b"}, correct_b, exp_corr_b);
        check_val({tag, "_tot_b"}, total_b, exp_tot_b);
        if (last) check_val({tag, "_done"}, done_a, 1);
        else      check_val({tag, "_next_cmp"}, comparing_a, 1);
    endtask

    task automatic finish_run(input string tag, input int nq);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_done_clr"}, done_a, 0);
        check_val({tag, "_idle"}, busy_a, 0);
        check_val({tag, "_pvalid_clr"}, pred_valid_a, 0);
        check_val({tag, "_held_tot"}, total_a, exp_tot_a);
        check_val({tag, "_held_corr"}, correct_a, exp_corr_a);
`ifdef AM_CYCLE_CNT_EN
        check_val({tag, "_cycles"}, cycle_cnt_a, nq * QLAT + 1);
`else
        check_val({tag, "_nq_seen"}, total_a, nq);
`endif
        step();
        check_val({tag, "_stay_idle"}, busy_a, 0);
    endtask

    initial begin
        int lbl, guard;
        rst = 1'b1; en = 1'b1; start = 1'b0; seg_valid = 1'b0;
        dataset_last = 1'b0; label_in = '0;
        fill_const(0);
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        start_run("peak");
        fill_const(5);
        score_tab[17] = 16'd90;
        run_query("peak_hit", 17, 1'b0, 1'b0);
        run_query("peak_miss", 3, 1'b1, 1'b0);
        finish_run("peak", 2);

        start_run("edge");
        fill_const(42);
        run_query("tie", 0, 1'b0, 1'b0);
        fill_const(7);
        score_tab[NC-1] = 16'd8;
        run_query("last_cls", NC - 1, 1'b1, 1'b0);
        finish_run("edge", 2);

        start_run("tog");
        for (int q = 0; q < 4; q++) begin
            fill_random();
            lbl = (q % 2 == 0) ? ref_argmax() : int'($urandom_range(0, NC - 1));
            run_query($sformatf("tog%0d", q), lbl, q == 3, 1'b1);
        end
        finish_run("tog", 4);

        start_run("abort");
        fill_const(5);
        score_tab[17] = 16'd90;
        label_in = 5'd17;
        dataset_last = 1'b0;
        seg_valid = 1'b1;
        guard = 0;
        while (!(inferring_a && class_idx_a == 5'd12) && guard < 200) begin
            step();
            guard++;
        end
        check_val("abort_reach_infer", inferring_a, 1);
        rst = 1'b1;
        step();
        check_all_zero("abort_rst");
        rst = 1'b0;
        step();
        start_run("restart");
        run_query("restart_q", 17, 1'b1, 1'b0);
        check_val("restart_first_ok", correct_a, 1);
        finish_run("restart", 1);

        start_run("sat");
        for (int q = 0; q < 5; q++) begin
            fill_random();
            run_query($sformatf("sat%0d", q), ref_argmax(), q == 4, 1'b0);
        end
        check_val("sat_corr_b", correct_b, 3);
        check_val("sat_corr_a", correct_a, 5);
        finish_run("sat", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
